// File: rtl/popcount_stream_acc.sv
// rtl/popcount_stream_acc.sv - masked popcount accumulated over a valid/ready beat stream, one held result per frame
// Optional threshold output is enabled by defining POPCNT_THRESH_EN.
module popcount_stream_acc #(
    parameter int CHUNK_W   = 25,
    parameter int MAX_BEATS = 8,
    parameter int OUT_W     = 8
`ifdef POPCNT_THRESH_EN
    ,
    parameter int THRESH    = 13
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CHUNK_W-1:0] in_data,
    input  logic [CHUNK_W-1:0] in_mask,
    input  logic               in_last,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [OUT_W-1:0]   out_count,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
`ifdef POPCNT_THRESH_EN
    ,
    output logic               out_fire
`endif
);

    localparam int CNT_W  = $clog2(CHUNK_W + 1);
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    localparam int SUM_W  = ((OUT_W > CNT_W) ? OUT_W : CNT_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [OUT_W-1:0]    r_acc;
    logic [OUT_W-1:0]    r_count;
    logic [BEAT_W-1:0]   r_beats;
    logic                r_err;

    logic [CHUNK_W-1:0]  w_masked;
    logic [CNT_W-1:0]    w_beat_cnt;
    logic                w_accept;
    logic [OUT_W-1:0]    w_acc_base;
    logic [BEAT_W-1:0]   w_beats_nxt;
    logic [SUM_W-1:0]    w_sum;
    logic [OUT_W-1:0]    w_sat;
    logic                w_at_max;
    logic                w_publish;

    assign w_masked = in_data & in_mask;

    always_comb begin
        w_beat_cnt = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            w_beat_cnt = w_beat_cnt + CNT_W'(w_masked[i]);
        end
    end

    // A beat taken in IDLE starts a fresh frame, so it adds onto zero.
    assign w_accept    = in_valid && (r_state != S_HOLD);
    assign w_acc_base  = (r_state == S_ACC) ? r_acc : '0;
    assign w_beats_nxt = (r_state == S_ACC) ? r_beats + 1'b1 : BEAT_W'(1);
    assign w_sum       = SUM_W'(w_acc_base) + SUM_W'(w_beat_cnt);
    assign w_sat       = (|w_sum[SUM_W-1:OUT_W]) ? '1 : w_sum[OUT_W-1:0];
    assign w_at_max    = (w_beats_nxt == BEAT_W'(MAX_BEATS));
    assign w_publish   = w_accept && (in_last || w_at_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_ACC: begin
                if (w_publish) begin
                    w_state_nxt = S_HOLD;
                end else if (w_accept) begin
                    w_state_nxt = S_ACC;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_beats <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_publish) begin
            r_count <= w_sat;
            r_err   <= !in_last;
            r_acc   <= '0;
            r_beats <= '0;
        end else if (w_accept) begin
            r_acc   <= w_sat;
            r_beats <= w_beats_nxt;
        end
    end

`ifdef POPCNT_THRESH_EN
    logic r_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fire <= 1'b0;
        end else if (w_publish) begin
            r_fire <= (32'(w_sat) >= 32'(THRESH));
        end
    end

    assign out_fire = r_fire;
`endif

    assign in_ready  = (r_state != S_HOLD);
    assign out_valid = (r_state == S_HOLD);
    assign out_count = r_count;
    assign out_err   = r_err;

endmodule
